// File: rtl/decode_queue_if.sv
// decode_queue_if: decode-stage control types plus the fetch/execute handshake bundle
package decode_queue_pkg;
    typedef enum logic [3:0] {
        ALU_NONE, ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND, ALU_SLL, ALU_SRL,
        ALU_SRA, ALU_SLT, ALU_SLTU, ALU_SEQ, ALU_SNE, ALU_SGE, ALU_SGEU
    } ex_func;
    typedef enum logic [1:0] {RS1_VALUE, RS1_PC, RS1_ZERO} rs1_sel;
    typedef enum logic {RS2_VALUE, IMM_VALUE} rs2_sel;
    typedef enum logic [1:0] {WB_SRC_NONE, WB_SRC_ALU, WB_SRC_MEM, WB_SRC_PC4} wb_source_type;
    typedef enum logic [1:0] {PC_SRC_NONE, PC_SRC_PC_IMM, PC_SRC_RS1_IMM} wb_pc_source_type;
    typedef struct packed {
        ex_func           func;
        rs1_sel           a_sel;
        rs2_sel           b_sel;
        logic             mw;
        logic             mr;
        logic             wb;
        wb_source_type    wsrc;
        wb_pc_source_type psrc;
        logic             ill;
    } ctrl_t;
    localparam ctrl_t CTRL_NOP = '{func: ALU_NONE, a_sel: RS1_VALUE, b_sel: RS2_VALUE, mw: 1'b0,
                                   mr: 1'b0, wb: 1'b0, wsrc: WB_SRC_NONE, psrc: PC_SRC_NONE, ill: 1'b0};
    localparam ctrl_t CTRL_ILL = '{func: ALU_NONE, a_sel: RS1_VALUE, b_sel: RS2_VALUE, mw: 1'b0,
                                   mr: 1'b0, wb: 1'b0, wsrc: WB_SRC_NONE, psrc: PC_SRC_NONE, ill: 1'b1};
endpackage

interface decode_queue_if #(parameter int XLEN = 32, parameter int QUEUE_DEPTH = 4);
    import decode_queue_pkg::*;
    logic                         flush_i;
    logic                         in_valid_i;
    logic                         in_ready_o;
    logic [31:0]                  in_instr_i;
    logic [XLEN-1:0]              in_pc_i;
    logic                         out_valid_o;
    logic                         out_ready_i;
    logic [XLEN-1:0]              out_pc_o;
    logic [31:0]                  out_instr_o;
    logic [4:0]                   out_rd_o;
    logic [4:0]                   out_rs1_o;
    logic [4:0]                   out_rs2_o;
    ex_func                       ex_func_o;
    rs1_sel                       rs1_sel_o;
    rs2_sel                       rs2_sel_o;
    logic                         memwrite_en_o;
    logic                         memread_en_o;
    logic                         wb_en_o;
    wb_source_type                wb_src_o;
    wb_pc_source_type             wb_pc_src_o;
    logic                         illegal_o;
    logic [$clog2(QUEUE_DEPTH):0] count_o;
    modport slave (
        input  flush_i, in_valid_i, in_instr_i, in_pc_i, out_ready_i,
        output in_ready_o, out_valid_o, out_pc_o, out_instr_o, out_rd_o, out_rs1_o, out_rs2_o,
               ex_func_o, rs1_sel_o, rs2_sel_o, memwrite_en_o, memread_en_o, wb_en_o,
               wb_src_o, wb_pc_src_o, illegal_o, count_o
    );
    modport master (
        output flush_i, in_valid_i, in_instr_i, in_pc_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_pc_o, out_instr_o, out_rd_o, out_rs1_o, out_rs2_o,
               ex_func_o, rs1_sel_o, rs2_sel_o, memwrite_en_o, memread_en_o, wb_en_o,
               wb_src_o, wb_pc_src_o, illegal_o, count_o
    );
endinterface

// File: rtl/decode_queue.sv
// decode_queue: instruction FIFO + decoder + output register; DECODE_BYPASS_EN lets an empty queue feed the output directly
module decode_queue import decode_queue_pkg::*; #(
    parameter int XLEN        = 32,
    parameter int QUEUE_DEPTH = 4
) (
    input logic          clk_i,
    input logic          rst_i,
    decode_queue_if.slave q
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } entry_t;

    entry_t        mem_q [QUEUE_DEPTH];
    entry_t        mem_d [QUEUE_DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          out_valid_q, out_valid_d;
    entry_t        out_q, out_d;
    ctrl_t         ctrl_q, ctrl_d;
    entry_t        in_entry, src;
    logic          in_ready, can_load, push_ok, bypass, pop, push_fifo, load;

    function automatic ex_func alu_op(input logic [2:0] f3, input logic alt);
        return f3 == 3'b000 ? (alt ? ALU_SUB : ALU_ADD) :
               f3 == 3'b001 ? ALU_SLL :
               f3 == 3'b010 ? ALU_SLT :
               f3 == 3'b011 ? ALU_SLTU :
               f3 == 3'b100 ? ALU_XOR :
               f3 == 3'b101 ? (alt ? ALU_SRA : ALU_SRL) :
               f3 == 3'b110 ? ALU_OR : ALU_AND;
    endfunction

    function automatic ctrl_t decode(input logic [31:0] i);
        ctrl_t      c;
        logic       ok;
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = i[14:12];
        f7 = i[31:25];
        c  = CTRL_NOP;
        ok = 1'b0;
        case (i[6:0])
            7'b0110111, 7'b0010111: begin
                ok = 1'b1; c.func = ALU_ADD; c.a_sel = i[5] ? RS1_ZERO : RS1_PC;
                c.b_sel = IMM_VALUE; c.wb = 1'b1; c.wsrc = WB_SRC_ALU;
            end
            7'b1101111: begin
                ok = 1'b1; c.func = ALU_ADD; c.a_sel = RS1_PC; c.b_sel = IMM_VALUE;
                c.wb = 1'b1; c.wsrc = WB_SRC_PC4; c.psrc = PC_SRC_PC_IMM;
            end
            7'b1100111: begin
                ok = f3 == 3'b000; c.func = ALU_ADD; c.b_sel = IMM_VALUE;
                c.wb = 1'b1; c.wsrc = WB_SRC_PC4; c.psrc = PC_SRC_RS1_IMM;
            end
            7'b1100011: begin
                ok = f3[2:1] != 2'b01; c.psrc = PC_SRC_PC_IMM;
                c.func = f3 == 3'b000 ? ALU_SEQ : f3 == 3'b001 ? ALU_SNE :
                         f3 == 3'b100 ? ALU_SLT : f3 == 3'b101 ? ALU_SGE :
                         f3 == 3'b110 ? ALU_SLTU : ALU_SGEU;
            end
            7'b0000011: begin
                ok = f3 != 3'b011 && f3[2:1] != 2'b11; c.func = ALU_ADD; c.b_sel = IMM_VALUE;
                c.mr = 1'b1; c.wb = 1'b1; c.wsrc = WB_SRC_MEM;
            end
            7'b0100011: begin
                ok = !f3[2] && f3[1:0] != 2'b11; c.func = ALU_ADD; c.b_sel = IMM_VALUE; c.mw = 1'b1;
            end
            7'b0010011: begin
                ok = f3 == 3'b001 ? f7 == 7'h00 : f3 == 3'b101 ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
                c.func = alu_op(f3, f3 == 3'b101 && i[30]); c.b_sel = IMM_VALUE;
                c.wb = 1'b1; c.wsrc = WB_SRC_ALU;
            end
            7'b0110011: begin
                ok = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
                c.func = alu_op(f3, i[30]); c.wb = 1'b1; c.wsrc = WB_SRC_ALU;
            end
            7'b0001111, 7'b1110011: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return (ok && i[1:0] == 2'b11) ? c : CTRL_ILL;
    endfunction

    assign in_entry  = '{pc: q.in_pc_i, instr: q.in_instr_i};
    assign in_ready  = count_q != CW'(QUEUE_DEPTH);
    assign push_ok   = q.in_valid_i && in_ready && !q.flush_i;
    assign can_load  = (!out_valid_q || q.out_ready_i) && !q.flush_i;
`ifdef DECODE_BYPASS_EN
    assign bypass    = push_ok && count_q == '0 && can_load;
`else
    assign bypass    = 1'b0;
`endif
    assign pop       = count_q != '0 && can_load;
    assign push_fifo = push_ok && !bypass;
    assign load      = pop || bypass;
    assign src       = bypass ? in_entry : mem_q[rd_ptr_q];

    // next-state for queue storage, pointers, occupancy and the decoded output register
    always_comb begin
        mem_d       = mem_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        ctrl_d      = ctrl_q;
        if (q.flush_i) begin
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            count_d     = '0;
            out_valid_d = 1'b0;
        end else begin
            if (push_fifo) begin
                mem_d[wr_ptr_q] = in_entry;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            rd_ptr_d    = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
            count_d     = count_q + CW'(push_fifo) - CW'(pop);
            out_valid_d = load || (out_valid_q && !q.out_ready_i);
            out_d       = load ? src : out_q;
            ctrl_d      = load ? decode(src.instr) : ctrl_q;
        end
    end

    // state registers; reset clears everything without waiting for a clock
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q       <= '{default: '0};
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            ctrl_q      <= CTRL_NOP;
        end else begin
            mem_q       <= mem_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            ctrl_q      <= ctrl_d;
        end
    end

    assign q.in_ready_o    = in_ready;
    assign q.count_o       = count_q;
    assign q.out_valid_o   = out_valid_q;
    assign q.out_pc_o      = out_q.pc;
    assign q.out_instr_o   = out_q.instr;
    assign q.out_rd_o      = out_q.instr[11:7];
    assign q.out_rs1_o     = out_q.instr[19:15];
    assign q.out_rs2_o     = out_q.instr[24:20];
    assign q.ex_func_o     = ctrl_q.func;
    assign q.rs1_sel_o     = ctrl_q.a_sel;
    assign q.rs2_sel_o     = ctrl_q.b_sel;
    assign q.memwrite_en_o = ctrl_q.mw;
    assign q.memread_en_o  = ctrl_q.mr;
    assign q.wb_en_o       = ctrl_q.wb;
    assign q.wb_src_o      = ctrl_q.wsrc;
    assign q.wb_pc_src_o   = ctrl_q.psrc;
    assign q.illegal_o     = ctrl_q.ill;
endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: table-driven decode vectors plus directed queue/handshake sequences
module tb_decode_queue;
    import decode_queue_pkg::*;

    typedef struct {
        logic [31:0]      instr;
        ex_func           f;
        rs1_sel           a;
        rs2_sel           b;
        logic             mw;
        logic             mr;
        logic             wb;
        wb_source_type    ws;
        wb_pc_source_type ps;
        logic             ill;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    vec_t vt [13];

    always #5 clk = ~clk;

    decode_queue_if #(.XLEN(32), .QUEUE_DEPTH(4)) dq ();
    decode_queue #(.XLEN(32), .QUEUE_DEPTH(4)) dut (.clk_i(clk), .rst_i(rst), .q(dq));

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    // called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic push(input logic [31:0] ins, input logic [31:0] pc);
        int t;
        t = 0;
        dq.in_valid_i = 1'b1;
        dq.in_instr_i = ins;
        dq.in_pc_i    = pc;
        while (!dq.in_ready_o && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 50) chk("push_timeout", 32'(dq.in_ready_o), 32'd1);
        @(posedge clk); #1;
        dq.in_valid_i = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int t;
`ifdef DECODE_BYPASS_EN
        lat = 1;
`else
        lat = 2;
`endif
        vt[0]  = '{32'h00500093, ALU_ADD,  RS1_VALUE, IMM_VALUE, 1'b0, 1'b0, 1'b1, WB_SRC_ALU,  PC_SRC_NONE,    1'b0};
        vt[1]  = '{32'h0000007F, ALU_NONE, RS1_VALUE, RS2_VALUE, 1'b0, 1'b0, 1'b0, WB_SRC_NONE, PC_SRC_NONE,    1'b1};
        vt[2]  = '{32'h0000A103, ALU_ADD,  RS1_VALUE, IMM_VALUE, 1'b0, 1'b1, 1'b1, WB_SRC_MEM,  PC_SRC_NONE,    1'b0};
        vt[3]  = '{32'h00209463, ALU_SNE,  RS1_VALUE, RS2_VALUE, 1'b0, 1'b0, 1'b0, WB_SRC_NONE, PC_SRC_PC_IMM,  1'b0};
        vt[4]  = '{32'h0020A023, ALU_ADD,  RS1_VALUE, IMM_VALUE, 1'b1, 1'b0, 1'b0, WB_SRC_NONE, PC_SRC_NONE,    1'b0};
        vt[5]  = '{32'h40208033, ALU_SUB,  RS1_VALUE, RS2_VALUE, 1'b0, 1'b0, 1'b1, WB_SRC_ALU,  PC_SRC_NONE,    1'b0};
        vt[6]  = '{32'h0000006F, ALU_ADD,  RS1_PC,    IMM_VALUE, 1'b0, 1'b0, 1'b1, WB_SRC_PC4,  PC_SRC_PC_IMM,  1'b0};
        vt[7]  = '{32'h00008067, ALU_ADD,  RS1_VALUE, IMM_VALUE, 1'b0, 1'b0, 1'b1, WB_SRC_PC4,  PC_SRC_RS1_IMM, 1'b0};
        vt[8]  = '{32'h000010B7, ALU_ADD,  RS1_ZERO,  IMM_VALUE, 1'b0, 1'b0, 1'b1, WB_SRC_ALU,  PC_SRC_NONE,    1'b0};
        vt[9]  = '{32'h0000000F, ALU_NONE, RS1_VALUE, RS2_VALUE, 1'b0, 1'b0, 1'b0, WB_SRC_NONE, PC_SRC_NONE,    1'b0};
        vt[10] = '{32'h00000073, ALU_NONE, RS1_VALUE, RS2_VALUE, 1'b0, 1'b0, 1'b0, WB_SRC_NONE, PC_SRC_NONE,    1'b0};
        vt[11] = '{32'h02208033, ALU_NONE, RS1_VALUE, RS2_VALUE, 1'b0, 1'b0, 1'b0, WB_SRC_NONE, PC_SRC_NONE,    1'b1};
        vt[12] = '{32'h40005093, ALU_SRA,  RS1_VALUE, IMM_VALUE, 1'b0, 1'b0, 1'b1, WB_SRC_ALU,  PC_SRC_NONE,    1'b0};

        dq.flush_i = 1'b0; dq.in_valid_i = 1'b0; dq.in_instr_i = '0; dq.in_pc_i = '0; dq.out_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_count", 32'(dq.count_o), 32'd0);
        chk("rst_in_ready", 32'(dq.in_ready_o), 32'd1);
        chk("rst_out_valid", 32'(dq.out_valid_o), 32'd0);
        chk("rst_pc", dq.out_pc_o, 32'd0);
        chk("rst_instr", dq.out_instr_o, 32'd0);
        chk("rst_regidx", 32'({dq.out_rd_o, dq.out_rs1_o, dq.out_rs2_o}), 32'd0);
        chk("rst_func", 32'(dq.ex_func_o), 32'(ALU_NONE));
        chk("rst_rs1_sel", 32'(dq.rs1_sel_o), 32'(RS1_VALUE));
        chk("rst_rs2_sel", 32'(dq.rs2_sel_o), 32'(RS2_VALUE));
        chk("rst_enables", 32'({dq.memwrite_en_o, dq.memread_en_o, dq.wb_en_o, dq.illegal_o}), 32'd0);
        chk("rst_wb_src", 32'(dq.wb_src_o), 32'(WB_SRC_NONE));
        chk("rst_pc_src", 32'(dq.wb_pc_src_o), 32'(PC_SRC_NONE));
        @(posedge clk); #1 rst = 1'b0;

        // asynchronous reset in the middle of a burst
        push(32'h00500093, 32'h40);
        push(32'h00500093, 32'h44);
        @(negedge clk);
        chk("burst_count", 32'(dq.count_o), 32'd1);
        chk("burst_valid", 32'(dq.out_valid_o), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_count", 32'(dq.count_o), 32'd0);
        chk("async_rst_valid", 32'(dq.out_valid_o), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // first-instruction latency after reset
        dq.out_ready_i = 1'b1;
        push(32'h00500093, 32'h100);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            chk("lat_valid", 32'(dq.out_valid_o), 32'(k == lat));
        end
        chk("lat_pc", dq.out_pc_o, 32'h100);
        chk("lat_func", 32'(dq.ex_func_o), 32'(ALU_ADD));
        chk("lat_rs2_sel", 32'(dq.rs2_sel_o), 32'(IMM_VALUE));
        chk("lat_wb_en", 32'(dq.wb_en_o), 32'd1);
        chk("lat_rd", 32'(dq.out_rd_o), 32'd1);
        @(posedge clk); #1;

        // decode table
        for (int i = 0; i < 13; i++) begin
            push(vt[i].instr, 32'h400 + 32'(i * 4));
            t = 0;
            @(negedge clk);
            while (!dq.out_valid_o && t < 4) begin
                @(negedge clk);
                t++;
            end
            chk("vec_valid", 32'(dq.out_valid_o), 32'd1);
            chk("vec_instr", dq.out_instr_o, vt[i].instr);
            chk("vec_func", 32'(dq.ex_func_o), 32'(vt[i].f));
            chk("vec_rs1_sel", 32'(dq.rs1_sel_o), 32'(vt[i].a));
            chk("vec_rs2_sel", 32'(dq.rs2_sel_o), 32'(vt[i].b));
            chk("vec_mw_mr_wb", 32'({dq.memwrite_en_o, dq.memread_en_o, dq.wb_en_o}), 32'({vt[i].mw, vt[i].mr, vt[i].wb}));
            chk("vec_wb_src", 32'(dq.wb_src_o), 32'(vt[i].ws));
            chk("vec_pc_src", 32'(dq.wb_pc_src_o), 32'(vt[i].ps));
            chk("vec_illegal", 32'(dq.illegal_o), 32'(vt[i].ill));
            @(posedge clk); #1;
        end

        // backpressure fill, stall stability, then in-order drain
        dq.out_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) push(32'h00500093, 32'(i * 4));
        @(negedge clk);
        chk("fill_count", 32'(dq.count_o), 32'd4);
        chk("fill_in_ready", 32'(dq.in_ready_o), 32'd0);
        dq.in_valid_i = 1'b1; dq.in_pc_i = 32'h14;
        repeat (3) begin
            @(negedge clk);
            chk("stall_valid", 32'(dq.out_valid_o), 32'd1);
            chk("stall_pc", dq.out_pc_o, 32'h0);
            chk("stall_func", 32'(dq.ex_func_o), 32'(ALU_ADD));
            chk("stall_count", 32'(dq.count_o), 32'd4);
        end
        @(posedge clk); #1;
        dq.in_valid_i = 1'b0;
        dq.out_ready_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("drain_valid", 32'(dq.out_valid_o), 32'd1);
            chk("drain_pc", dq.out_pc_o, 32'(k * 4));
        end
        @(negedge clk);
        chk("drain_empty_valid", 32'(dq.out_valid_o), 32'd0);
        chk("drain_empty_count", 32'(dq.count_o), 32'd0);
        @(posedge clk); #1;

        // flush during a downstream stall, racing a push
        dq.out_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) push(32'h00500093, 32'h200 + 32'(i * 4));
        @(negedge clk);
        chk("preflush_count", 32'(dq.count_o), 32'd3);
        chk("preflush_valid", 32'(dq.out_valid_o), 32'd1);
        @(posedge clk); #1;
        dq.flush_i = 1'b1; dq.in_valid_i = 1'b1; dq.in_pc_i = 32'h300;
        @(posedge clk); #1;
        dq.flush_i = 1'b0; dq.in_valid_i = 1'b0;
        @(negedge clk);
        chk("flush_count", 32'(dq.count_o), 32'd0);
        chk("flush_valid", 32'(dq.out_valid_o), 32'd0);
        chk("flush_in_ready", 32'(dq.in_ready_o), 32'd1);
        dq.out_ready_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("flush_dropped", 32'(dq.out_valid_o), 32'd0);
        end
        @(posedge clk); #1;

        // pointer wrap with toggling downstream ready
        dq.out_ready_i = 1'b0;
        fork
            begin
                for (int i = 0; i < 20; i++) push(32'h00000013, 32'h1000 + 32'(i * 4));
            end
            begin
                int got;
                got = 0;
                for (int c = 0; c < 400 && got < 20; c++) begin
                    @(posedge clk); #1;
                    dq.out_ready_i = ~dq.out_ready_i;
                    @(negedge clk);
                    if (dq.out_valid_o && dq.out_ready_i) begin
                        chk("wrap_pc", dq.out_pc_o, 32'h1000 + 32'(got * 4));
                        got++;
                    end
                end
                chk("wrap_count", 32'(got), 32'd20);
            end
        join
        @(posedge clk); #1;
        dq.out_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        chk("wrap_no_dup", 32'(dq.out_valid_o), 32'd0);
        chk("wrap_final_count", 32'(dq.count_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
